// File: rtl/matmul_pkg.sv
// Shared defaults and state encoding for the matrix-multiply C-matrix drain.
package matmul_pkg;

  localparam int DWIDTH_DEF       = 8;
  localparam int MAT_MUL_SIZE_DEF = 8;
  localparam int AWIDTH_DEF       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/matmul_drain_fifo.sv
// Two-entry output buffer for the C drain; entry0 is always the head.
module matmul_drain_fifo #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry0;
  logic [WIDTH-1:0] entry1;
  logic [1:0]       cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (cnt != 2'd0);
  assign do_push  = push && ((cnt != 2'd2) || do_pop);
  assign pop_data = entry0;
  assign full     = (cnt == 2'd2);
  assign empty    = (cnt == 2'd0);
  assign count    = cnt;

  // Shift-register storage: a pop moves entry1 to the head, a push fills the first free slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      entry0 <= '0;
      entry1 <= '0;
      cnt    <= '0;
    end else begin
      if (do_pop) begin
        if (do_push && (cnt == 2'd1)) begin
          entry0 <= push_data;
        end else begin
          entry0 <= entry1;
          if (do_push) entry1 <= push_data;
        end
      end else if (do_push) begin
        if (cnt == 2'd0) entry0 <= push_data;
        else             entry1 <= push_data;
      end
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/matmul_c_drain.sv
// Drains rows of matrix C from a 1-cycle-latency BRAM into a valid/ready row stream.
// Optional feature: define MATMUL_C_DRAIN_COL_MASK_EN to add col_mask, which zeroes
// masked-off elements of every emitted row.
module matmul_c_drain #(
  parameter int DWIDTH       = matmul_pkg::DWIDTH_DEF,
  parameter int MAT_MUL_SIZE = matmul_pkg::MAT_MUL_SIZE_DEF,
  parameter int AWIDTH       = matmul_pkg::AWIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           start,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [15:0]                    addr_stride,
  input  logic [3:0]                     num_rows,
  output logic [AWIDTH-1:0]              bram_addr_c_ext,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_c_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_c_ext,
  output logic [MAT_MUL_SIZE-1:0]        bram_we_c_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic                           busy,
  output logic                           done,
  input  logic                           clear_done
`ifdef MATMUL_C_DRAIN_COL_MASK_EN
  ,
  input  logic [MAT_MUL_SIZE-1:0]        col_mask
`endif
);

  import matmul_pkg::*;

  localparam int RW = MAT_MUL_SIZE * DWIDTH;
  localparam int FW = RW + 1;

  drain_state_t state;
  drain_state_t state_nxt;

  logic [AWIDTH-1:0] addr_q;
  logic [15:0]       stride_q;
  logic [3:0]        rows_q;
  logic [3:0]        row_idx;
  logic              inflight;
  logic              inflight_last;
  logic              start_go;
  logic              room;
  logic              issue;
  logic              last_issue;
  logic              pop;

  logic [FW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [1:0]        fifo_count;

  assign bram_wdata_c_ext = '0;
  assign bram_we_c_ext    = '0;
  assign bram_addr_c_ext  = addr_q;

  assign start_go = (state == ST_IDLE) && start && (num_rows != 4'd0);
  assign pop      = !fifo_empty && m_ready;

  // Issue only when occupancy + in-flight - pop < 2, written out per in-flight case.
  assign room       = inflight ? (fifo_empty || ((fifo_count == 2'd1) && pop))
                               : (!fifo_full || pop);
  assign issue      = (state == ST_READ) && room;
  assign last_issue = issue && (row_idx == (rows_q - 4'd1));

  matmul_drain_fifo #(
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (inflight),
    .push_data ({inflight_last, bram_rdata_c_ext}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign m_last  = !fifo_empty && head[FW-1];

`ifdef MATMUL_C_DRAIN_COL_MASK_EN
  logic [MAT_MUL_SIZE-1:0] mask_q;

  // Column mask is captured with the drain parameters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       mask_q <= '0;
    else if (start_go) mask_q <= col_mask;
  end

  // Zero each masked-off element of the head row.
  always_comb begin
    m_data = head[RW-1:0];
    for (int unsigned i = 0; i < MAT_MUL_SIZE; i++) begin
      if (!mask_q[i]) m_data[i*DWIDTH +: DWIDTH] = '0;
    end
  end
`else
  assign m_data = head[RW-1:0];
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = (num_rows != 4'd0) ? ST_READ : ST_DONE;
      end
      ST_READ: begin
        busy = 1'b1;
        if (last_issue) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy = 1'b1;
        if (pop && head[FW-1]) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (clear_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read address generation and in-flight tracking; the address register holds
  // the issued address and only advances when a further row remains to be issued.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q        <= '0;
      stride_q      <= '0;
      rows_q        <= '0;
      row_idx       <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      if (start_go) begin
        addr_q   <= base_addr;
        stride_q <= addr_stride;
        rows_q   <= num_rows;
        row_idx  <= '0;
      end else if (issue && !last_issue) begin
        addr_q  <= addr_q + AWIDTH'(stride_q);
        row_idx <= row_idx + 4'd1;
      end
    end
  end

endmodule
